// File: rtl/ysyx_24110006_ifu.sv
// ysyx_24110006_ifu: instruction fetch unit -- owns the fetch PC, keeps one I-cache request in flight
// and presents each fetched instruction (or a misaligned-fetch fault) to the IDU through a registered slot.
module ysyx_24110006_ifu #(
   parameter logic [31:0] RESET_PC = 32'h3000_0000
) (
   input  logic        i_clock,
   input  logic        i_reset,
   output logic [31:0] o_icache_pc,
   output logic        o_icache_valid,
   input  logic [31:0] i_icache_inst,
   input  logic        i_icache_valid,
   output logic        o_idu_valid,
   input  logic        i_idu_ready,
   output logic [31:0] o_idu_inst,
   output logic [31:0] o_idu_pc,
   output logic        o_idu_misalign,
   input  logic        i_redirect_valid,
   input  logic [31:0] i_redirect_pc,
   output logic [31:0] o_perf_fetch_cnt,
   output logic [31:0] o_perf_wait_cnt
);
   typedef enum logic [1:0] {REQ, WAIT, HOLD, FAULT} state_t;
   state_t state, state_nx;
   logic [31:0] pc, req_pc, slot_inst, slot_pc, fetch_cnt, wait_cnt;
   logic drop, slot_mis, slot_valid;
   logic redir, mis, resp, take, busy, load;

   assign redir = i_redirect_valid;
   assign mis = redir && (i_redirect_pc[1:0] != 2'b00);
   assign resp = i_icache_valid;
   assign take = slot_valid && i_idu_ready;
   // a request is still owed a response: either waiting for it, or waiting to discard it
   assign busy = (state == WAIT) || drop;
   assign load = (state == WAIT) && resp && !drop && !redir;

   always_ff @(posedge i_clock) begin
      if (i_reset) state <= REQ;
      else state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      if (mis) state_nx = FAULT;
      else if (redir) state_nx = (busy && !resp) ? WAIT : REQ;
      else
         case (state)
            REQ:     state_nx = WAIT;
            WAIT:    state_nx = resp ? (drop ? REQ : HOLD) : WAIT;
            HOLD:    state_nx = take ? REQ : HOLD;
            default: state_nx = FAULT;
         endcase
   end

   // a redirect in REQ suppresses the pulse so no orphan request is left outstanding
   always_comb begin
      o_icache_valid = (state == REQ) && !redir && !i_reset;
      o_icache_pc = (state == REQ) ? pc : req_pc;
   end

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         pc <= RESET_PC;
         req_pc <= RESET_PC;
         drop <= 1'b0;
         slot_inst <= 32'd0;
         slot_pc <= RESET_PC;
         slot_mis <= 1'b0;
         slot_valid <= 1'b0;
         fetch_cnt <= 32'd0;
         wait_cnt <= 32'd0;
      end else begin
         if (o_icache_valid) req_pc <= pc;
         if (redir) pc <= i_redirect_pc;
         else if (load) pc <= req_pc + 32'd4;
         drop <= redir ? (busy && !resp) : (drop && !resp);
         if (mis) begin
            slot_inst <= 32'd0;
            slot_pc <= i_redirect_pc;
            slot_mis <= 1'b1;
            slot_valid <= 1'b1;
         end else if (redir) begin
            slot_mis <= 1'b0;
            slot_valid <= 1'b0;
         end else if (load) begin
            slot_inst <= i_icache_inst;
            slot_pc <= req_pc;
            slot_mis <= 1'b0;
            slot_valid <= 1'b1;
         end else if (take) slot_valid <= 1'b0;
         if (state == HOLD && take) fetch_cnt <= fetch_cnt + 32'd1;
         if (state == WAIT) wait_cnt <= wait_cnt + 32'd1;
      end
   end

   assign o_idu_valid = slot_valid;
   assign o_idu_inst = slot_inst;
   assign o_idu_pc = slot_pc;
   assign o_idu_misalign = slot_mis;
   assign o_perf_fetch_cnt = fetch_cnt;
   assign o_perf_wait_cnt = wait_cnt;
endmodule

// File: tb/tb_ysyx_24110006_ifu.sv
// tb_ysyx_24110006_ifu: directed bench for the fetch unit; an I-cache responder with programmable latency
// plus a per-cycle behavioural model of the fetch stream checked on every falling edge.
module tb_ysyx_24110006_ifu;
   localparam logic [31:0] RST = 32'h3000_0000;
   logic i_clock, i_reset, o_icache_valid, i_icache_valid, o_idu_valid, i_idu_ready;
   logic o_idu_misalign, i_redirect_valid;
   logic [31:0] o_icache_pc, i_icache_inst, o_idu_inst, o_idu_pc, i_redirect_pc;
   logic [31:0] o_perf_fetch_cnt, o_perf_wait_cnt;
   int n_cmp = 0, n_bad = 0;
   int lat = 2, cd = 0;
   logic [31:0] raddr = 0;

   ysyx_24110006_ifu dut (
      .i_clock(i_clock), .i_reset(i_reset),
      .o_icache_pc(o_icache_pc), .o_icache_valid(o_icache_valid),
      .i_icache_inst(i_icache_inst), .i_icache_valid(i_icache_valid),
      .o_idu_valid(o_idu_valid), .i_idu_ready(i_idu_ready),
      .o_idu_inst(o_idu_inst), .o_idu_pc(o_idu_pc), .o_idu_misalign(o_idu_misalign),
      .i_redirect_valid(i_redirect_valid), .i_redirect_pc(i_redirect_pc),
      .o_perf_fetch_cnt(o_perf_fetch_cnt), .o_perf_wait_cnt(o_perf_wait_cnt)
   );

   initial i_clock = 1'b0;
   always #5 i_clock = ~i_clock;

   function automatic logic [31:0] mem(input logic [31:0] a);
      return a ^ 32'h1357_9BDF;
   endfunction

   task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
      n_cmp++;
      if (a !== e) begin
         n_bad++;
         $display("FAIL %s: got %h want %h at %0t", n, a, e, $time);
      end
   endtask

   // advance one cycle; the I-cache answers 'lat' cycles after a request, forgets it on reset
   task automatic step();
      @(negedge i_clock);
      if (i_reset) cd = 0;
      else if (o_icache_valid) begin
         cd = lat;
         raddr = o_icache_pc;
      end
      @(posedge i_clock);
      #1;
      i_icache_valid = 1'b0;
      if (cd != 0) begin
         cd--;
         if (cd == 0) begin
            i_icache_valid = 1'b1;
            i_icache_inst = mem(raddr);
         end
      end
   endtask

   task automatic wait_req();
      for (int n = 0; n < 60 && !o_icache_valid; n++) step();
      chk("req_timeout", {31'd0, o_icache_valid}, 32'd1);
   endtask

   task automatic wait_idu();
      for (int n = 0; n < 60 && !o_idu_valid; n++) step();
      chk("idu_timeout", {31'd0, o_idu_valid}, 32'd1);
   endtask

   // behavioural model: expected fetch PC, outstanding request, fault mode and counters
   logic [31:0] m_pc = RST, m_addr = RST, m_ftgt = 0, m_fetch = 0, m_wait = 0;
   logic m_out = 0, m_fault = 0, m_ftaken = 0, m_kill = 0, m_expf = 0, p_hold = 0;
   logic [31:0] p_inst = 0, p_pc = 0;
   logic p_mis = 0;

   always @(negedge i_clock) begin
      if (i_reset) begin
         chk("rst_no_req", {31'd0, o_icache_valid}, 32'd0);
         m_pc = RST; m_fetch = 0; m_wait = 0;
         m_out = 0; m_fault = 0; m_ftaken = 0; m_kill = 0; m_expf = 0; p_hold = 0;
      end else begin
         chk("fetch_cnt", o_perf_fetch_cnt, m_fetch);
         chk("wait_cnt", o_perf_wait_cnt, m_wait);
         if (o_icache_valid) begin
            chk("req_while_outstanding", {31'd0, m_out}, 32'd0);
            chk("req_in_fault", {31'd0, m_fault}, 32'd0);
            chk("req_pc", o_icache_pc, m_pc);
         end
         if (m_out) chk("icache_pc_stable", o_icache_pc, m_addr);
         if (m_kill) chk("valid_after_redirect", {31'd0, o_idu_valid}, 32'd0);
         if (m_expf) chk("fault_valid", {31'd0, o_idu_valid}, 32'd1);
         if (m_ftaken) chk("fault_taken_idle", {31'd0, o_idu_valid}, 32'd0);
         if (p_hold) begin
            chk("hold_valid", {31'd0, o_idu_valid}, 32'd1);
            chk("hold_inst", o_idu_inst, p_inst);
            chk("hold_pc", o_idu_pc, p_pc);
            chk("hold_mis", {31'd0, o_idu_misalign}, {31'd0, p_mis});
         end
         if (o_idu_valid) begin
            chk("idu_mis", {31'd0, o_idu_misalign}, {31'd0, m_fault});
            chk("idu_pc", o_idu_pc, m_fault ? m_ftgt : m_pc);
            chk("idu_inst", o_idu_inst, m_fault ? 32'd0 : mem(m_pc));
         end
         p_hold = o_idu_valid && !i_idu_ready && !i_redirect_valid;
         p_inst = o_idu_inst; p_pc = o_idu_pc; p_mis = o_idu_misalign;
         m_kill = 0; m_expf = 0;
         if (m_out && !m_fault) m_wait++;
         if (o_idu_valid && i_idu_ready) begin
            if (m_fault) m_ftaken = 1;
            else begin
               m_fetch++;
               m_pc = m_pc + 32'd4;
            end
         end
         if (i_icache_valid) m_out = 0;
         if (o_icache_valid) begin
            m_out = 1;
            m_addr = m_pc;
         end
         if (i_redirect_valid) begin
            m_pc = i_redirect_pc;
            m_ftaken = 0;
            if (i_redirect_pc[1:0] != 2'b00) begin
               m_fault = 1; m_ftgt = i_redirect_pc; m_expf = 1;
            end else begin
               m_fault = 0; m_kill = 1;
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: bench did not finish");
      $fatal(1);
   end

   initial begin
      i_reset = 1; i_idu_ready = 1; i_redirect_valid = 0; i_redirect_pc = 0;
      i_icache_valid = 0; i_icache_inst = 0;
      repeat (3) step();
      #1;
      chk("rst_icache_valid", {31'd0, o_icache_valid}, 32'd0);
      chk("rst_idu_valid", {31'd0, o_idu_valid}, 32'd0);
      chk("rst_idu_inst", o_idu_inst, 32'd0);
      chk("rst_idu_pc", o_idu_pc, RST);
      chk("rst_idu_mis", {31'd0, o_idu_misalign}, 32'd0);
      chk("rst_fetch_cnt", o_perf_fetch_cnt, 32'd0);
      chk("rst_wait_cnt", o_perf_wait_cnt, 32'd0);
      // c0: first cycle out of reset issues the first request
      step(); i_reset = 0; #1;
      chk("first_req_valid", {31'd0, o_icache_valid}, 32'd1);
      chk("first_req_pc", o_icache_pc, 32'h3000_0000);
      repeat (3) step(); #1;
      chk("c3_idu_valid", {31'd0, o_idu_valid}, 32'd1);
      chk("c3_idu_pc", o_idu_pc, 32'h3000_0000);
      chk("c3_idu_inst", o_idu_inst, 32'h2357_9BDF);
      repeat (8) step(); #1;
      chk("c11_idu_pc", o_idu_pc, 32'h3000_0008);
      chk("c11_idu_inst", o_idu_inst, 32'h2357_9BD7);
      step(); i_idu_ready = 0; #1;
      chk("c12_fetch_cnt", o_perf_fetch_cnt, 32'd3);
      chk("c12_wait_cnt", o_perf_wait_cnt, 32'd6);
      // IDU stalls ten cycles in HOLD
      repeat (3) step(); #1;
      chk("c15_idu_pc", o_idu_pc, 32'h3000_000C);
      chk("c15_idu_inst", o_idu_inst, 32'h2357_9BD3);
      repeat (9) step(); #1;
      chk("c24_idu_pc", o_idu_pc, 32'h3000_000C);
      chk("c24_no_req", {31'd0, o_icache_valid}, 32'd0);
      chk("c24_fetch_cnt", o_perf_fetch_cnt, 32'd3);
      step(); i_idu_ready = 1; lat = 20;
      step(); #1;
      chk("c26_fetch_cnt", o_perf_fetch_cnt, 32'd4);
      chk("c26_req_pc", o_icache_pc, 32'h3000_0010);
      // redirect two cycles into a 20-cycle miss
      repeat (2) step(); i_redirect_valid = 1; i_redirect_pc = 32'h3000_0100;
      step(); i_redirect_valid = 0; #1;
      chk("c29_wait_cnt", o_perf_wait_cnt, 32'd10);
      repeat (11) step(); #1;
      chk("c40_old_pc", o_icache_pc, 32'h3000_0010);
      lat = 2;
      repeat (7) step(); #1;
      chk("c47_req_valid", {31'd0, o_icache_valid}, 32'd1);
      chk("c47_req_pc", o_icache_pc, 32'h3000_0100);
      chk("c47_wait_cnt", o_perf_wait_cnt, 32'd28);
      repeat (3) step(); #1;
      chk("c50_idu_pc", o_idu_pc, 32'h3000_0100);
      chk("c50_idu_inst", o_idu_inst, 32'h2357_9ADF);
      // redirect coincident with the response
      repeat (3) step(); i_redirect_valid = 1; i_redirect_pc = 32'h3000_0180;
      step(); i_redirect_valid = 0; #1;
      chk("c54_req_valid", {31'd0, o_icache_valid}, 32'd1);
      chk("c54_req_pc", o_icache_pc, 32'h3000_0180);
      chk("c54_fetch_cnt", o_perf_fetch_cnt, 32'd5);
      repeat (3) step(); #1;
      chk("c57_idu_inst", o_idu_inst, 32'h2357_9A5F);
      // misaligned redirect while a fetch is in flight
      repeat (2) step(); i_idu_ready = 0; i_redirect_valid = 1; i_redirect_pc = 32'h3000_0102;
      step(); i_redirect_valid = 0; #1;
      chk("c60_fault_valid", {31'd0, o_idu_valid}, 32'd1);
      chk("c60_fault_mis", {31'd0, o_idu_misalign}, 32'd1);
      chk("c60_fault_inst", o_idu_inst, 32'd0);
      chk("c60_fault_pc", o_idu_pc, 32'h3000_0102);
      repeat (4) step(); i_idu_ready = 1; #1;
      chk("c64_no_req", {31'd0, o_icache_valid}, 32'd0);
      step(); #1;
      chk("c65_idle", {31'd0, o_idu_valid}, 32'd0);
      chk("c65_fetch_cnt", o_perf_fetch_cnt, 32'd6);
      chk("c65_wait_cnt", o_perf_wait_cnt, 32'd35);
      step(); i_redirect_valid = 1; i_redirect_pc = 32'h3000_0200;
      step(); i_redirect_valid = 0; #1;
      chk("c67_req_pc", o_icache_pc, 32'h3000_0200);
      chk("c67_req_valid", {31'd0, o_icache_valid}, 32'd1);
      repeat (3) step(); lat = 20; #1;
      chk("c70_idu_inst", o_idu_inst, 32'h2357_99DF);
      // fault raised during a miss, then an aligned redirect before the stale response lands
      repeat (2) step(); i_redirect_valid = 1; i_redirect_pc = 32'h3000_0301;
      step(); i_redirect_valid = 0; #1;
      chk("c73_fault_pc", o_idu_pc, 32'h3000_0301);
      repeat (3) step(); i_redirect_valid = 1; i_redirect_pc = 32'h3000_0400;
      step(); i_redirect_valid = 0; lat = 2; #1;
      chk("c77_no_req", {31'd0, o_icache_valid}, 32'd0);
      wait_req(); #1;
      chk("late_req_pc", o_icache_pc, 32'h3000_0400);
      wait_idu(); #1;
      chk("late_idu_inst", o_idu_inst, 32'h2357_9FDF);
      // reset while in WAIT
      step(); wait_req(); step();
      i_reset = 1; #1;
      chk("mid_rst_no_req", {31'd0, o_icache_valid}, 32'd0);
      step(); i_reset = 0; #1;
      chk("mid_rst_idu_valid", {31'd0, o_idu_valid}, 32'd0);
      chk("mid_rst_idu_pc", o_idu_pc, RST);
      chk("mid_rst_idu_inst", o_idu_inst, 32'd0);
      chk("mid_rst_fetch_cnt", o_perf_fetch_cnt, 32'd0);
      chk("mid_rst_wait_cnt", o_perf_wait_cnt, 32'd0);
      chk("mid_rst_req_pc", o_icache_pc, RST);
      chk("mid_rst_req_valid", {31'd0, o_icache_valid}, 32'd1);
      wait_idu(); #1;
      chk("post_rst_idu_pc", o_idu_pc, RST);
      chk("post_rst_idu_inst", o_idu_inst, 32'h2357_9BDF);
      repeat (4) step();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
